or4_vec_checker: RTL and testbench
==================================

OR4_VEC_CHECKER -- requirements
Module: or4_vec_checker

Interface
- REQ-001: The module SHALL have parameter SETTLE_CYC, default 2, which is the number of CK cycles each input vector is held before ZN is sampled; the legal range is 1..15.
- REQ-002: CK  input  1  is the single clock; all state changes on the rising edge.
- REQ-003: RN  input  1  is reset, asynchronous and active-low.
- REQ-004: START  input  1  is a one-cycle run request.
- REQ-005: INV  input  1  selects the expected function: 0 = OR4, 1 = NOR4; it is sampled at the START edge.
- REQ-006: ZN  input  1  is the output of the gate under test.
- REQ-007: A1, A2, A3, A4  output  1 each  drive the gate under test; they are registered.
- REQ-008: BUSY  output  1  is high while the sweep is running.
- REQ-009: DONE  output  1  is high once a sweep has completed; it holds until the next START or reset.
- REQ-010: ERR_CNT  output  5  is the number of mismatching vectors, 0..16.
- REQ-011: FAIL_VALID  output  1  is high when at least one mismatch has been recorded.
- REQ-012: FIRST_FAIL  output  4  is the first mismatching vector in {A1,A2,A3,A4} order.

Function
- REQ-013: The FSM SHALL have three states: IDLE, RUN, DONE.
- REQ-014: On START=1 in IDLE or DONE, the next edge SHALL:
  - enter RUN;
  - set vec=0 and the settle counter to 0;
  - latch INV;
  - clear ERR_CNT, FAIL_VALID and FIRST_FAIL;
  - drop DONE.
- REQ-015: In RUN, {A1,A2,A3,A4} SHALL equal vec, with A1 = vec[3] (MSB) and A4 = vec[0].
- REQ-016: Each vector SHALL be held for exactly SETTLE_CYC cycles.
- REQ-017: ZN SHALL be sampled only at the edge that ends a vector's last settle cycle.
- REQ-018: Expected value SHALL be (|vec) XOR latched INV.
- REQ-019: A mismatch SHALL be declared when ZN differs from the expected value; ZN equal to X or Z SHALL also count as a mismatch.
- REQ-020: On a mismatch, ERR_CNT SHALL increment by 1; it cannot exceed 16, so no saturation logic is required.
- REQ-021: On the first mismatch of a run, FIRST_FAIL SHALL be loaded with vec and FAIL_VALID set to 1; later mismatches SHALL leave FIRST_FAIL unchanged.
- REQ-022: At a sample edge with vec < 15, vec SHALL increment and the next vector SHALL appear on A1..A4 at that same edge.
- REQ-023: At the sample edge for vec = 15, the block SHALL:
  - enter DONE;
  - set DONE=1 and BUSY=0;
  - drive A1..A4 to 0.
- REQ-024: Total run length from the START edge to DONE=1 SHALL be exactly 16*SETTLE_CYC cycles.
- REQ-025: START while in RUN SHALL be ignored, with no restart and no counter change.
- REQ-026: ERR_CNT, FAIL_VALID and FIRST_FAIL SHALL hold their values in DONE until the next START.
- REQ-027: BUSY SHALL be 1 exactly while in RUN.
- REQ-028: In IDLE and DONE, A1..A4 SHALL be 0.
- REQ-029: SETTLE_CYC = 0 SHALL behave as 1.

Reset
- REQ-030: RN=0 SHALL immediately, without waiting for CK, force:
  - state to IDLE;
  - A1..A4 to 0;
  - BUSY, DONE and FAIL_VALID to 0;
  - ERR_CNT to 0;
  - FIRST_FAIL to 0;
  - vec and the settle counter to 0.
- REQ-031: Reset asserted mid-run SHALL abort the sweep and discard partial results.
- REQ-032: After RN deasserts, the block SHALL wait in IDLE for START.
- REQ-033: START sampled on the first edge after RN rises SHALL be honoured.

Verification
- REQ-034: Reset, SETTLE_CYC=2, ZN modelled as OR of A1..A4, INV=0, pulse START -> BUSY=1 for 32 cycles; then DONE=1, ERR_CNT=0, FAIL_VALID=0.
- REQ-035: ZN tied to 0, INV=0, START -> DONE after 32 cycles; ERR_CNT=15, FIRST_FAIL=4'b0001, FAIL_VALID=1.
- REQ-036: ZN tied to 1, INV=0, START -> ERR_CNT=1, FIRST_FAIL=4'b0000; check that A1..A4 step 0000..1111, changing every 2 cycles.
- REQ-037: ZN modelled as OR4, INV=1, START -> ERR_CNT=16, FIRST_FAIL=4'b0000; then ZN modelled as NOR4, INV=1, START from DONE -> counters cleared at the START edge, final ERR_CNT=0.
- REQ-038: RN pulsed low 10 cycles into a run -> all outputs 0 immediately; after RN rises and a new START, the full 32-cycle sweep completes with correct results.
- REQ-039: START pulsed at cycle 5 of a run -> ignored; DONE still rises at cycle 32 and ERR_CNT is unchanged versus an unperturbed run.

Source files
------------

// File: rtl/or4_vec_checker.sv
// -----------------------------------------------------------------------------
// or4_vec_checker
//
// Exhaustive functional checker for a 4-input OR / NOR gate. On a START
// request it sweeps all 16 input vectors onto A1..A4 (A1 = MSB). Each vector
// is held for SETTLE_CYC clock cycles, and then the gate output ZN is compared
// with the expected value. The checker counts mismatches and records the
// first vector that failed.
//
// Parameters
//   SETTLE_CYC  cycles each vector is held before ZN is sampled (1..15;
//               a value of 0 behaves as 1)
//
// Ports
//   CK          clock; all state changes on the rising edge
//   RN          asynchronous, active-low reset
//   START       one-cycle run request; ignored while a sweep is running
//   INV         expected function, latched at START: 0 = OR4, 1 = NOR4
//   ZN          output of the gate under test
//   A1..A4      registered stimulus to the gate under test
//   BUSY        high while the sweep is running
//   DONE        high after a sweep completes; held until START or reset
//   ERR_CNT     number of mismatching vectors, 0..16
//   FAIL_VALID  high once at least one mismatch has been recorded
//   FIRST_FAIL  first mismatching vector, in {A1,A2,A3,A4} order
// -----------------------------------------------------------------------------
module or4_vec_checker #(
  parameter int SETTLE_CYC = 2
) (
  input  logic       CK,
  input  logic       RN,
  input  logic       START,
  input  logic       INV,
  input  logic       ZN,
  output logic       A1,
  output logic       A2,
  output logic       A3,
  output logic       A4,
  output logic       BUSY,
  output logic       DONE,
  output logic [4:0] ERR_CNT,
  output logic       FAIL_VALID,
  output logic [3:0] FIRST_FAIL
);

  // A hold time of zero would make no sense, so it is promoted to one cycle.
  localparam int         SETTLE_EFF  = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [3:0] vec;
  logic [3:0] settle_cnt;
  logic       inv_q;
  logic [3:0] a_q;
  logic [4:0] err_cnt_q;
  logic       fail_valid_q;
  logic [3:0] first_fail_q;

  logic       start_ok;
  logic       sample;
  logic       last_vec;
  logic       mismatch;

  // Expected gate output for a vector under the latched polarity.
  function automatic logic expected_zn(input logic [3:0] v, input logic inv);
    return (|v) ^ inv;
  endfunction

  // A strict four-state compare: if ZN is X or Z, the result is a mismatch
  // rather than a silent match. Synthesis reduces this to an ordinary
  // inequality.
  function automatic logic is_mismatch(input logic zn, input logic exp);
    return (zn === exp) ? 1'b0 : 1'b1;
  endfunction

  // START is only honoured outside a running sweep.
  assign start_ok = START && (state != S_RUN);

  // The sample point is the edge that closes the last settle cycle of the
  // current vector.
  assign sample   = (state == S_RUN) && (settle_cnt == SETTLE_LAST);
  assign last_vec = (vec == 4'hF);
  assign mismatch = is_mismatch(ZN, expected_zn(vec, inv_q));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (START) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (sample && last_vec) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (START) state_nxt = S_RUN;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sweep datapath: vector, settle counter, stimulus and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      vec          <= 4'd0;
      settle_cnt   <= 4'd0;
      inv_q        <= 1'b0;
      a_q          <= 4'd0;
      err_cnt_q    <= 5'd0;
      fail_valid_q <= 1'b0;
      first_fail_q <= 4'd0;
    end else if (start_ok) begin
      vec          <= 4'd0;
      settle_cnt   <= 4'd0;
      inv_q        <= INV;
      a_q          <= 4'd0;
      err_cnt_q    <= 5'd0;
      fail_valid_q <= 1'b0;
      first_fail_q <= 4'd0;
    end else if (state == S_RUN) begin
      if (sample) begin
        settle_cnt <= 4'd0;
        if (mismatch) begin
          // At most 16 vectors can fail, so the 5-bit count cannot wrap.
          err_cnt_q <= err_cnt_q + 5'd1;
          if (!fail_valid_q) begin
            fail_valid_q <= 1'b1;
            first_fail_q <= vec;
          end
        end
        if (last_vec) begin
          vec <= 4'd0;
          a_q <= 4'd0;
        end else begin
          // The next vector goes onto the pins at the same edge, so
          // no dead cycle appears between vectors.
          vec <= vec + 4'd1;
          a_q <= vec + 4'd1;
        end
      end else begin
        settle_cnt <= settle_cnt + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign {A1, A2, A3, A4} = a_q;
  assign BUSY             = (state == S_RUN);
  assign DONE             = (state == S_DONE);
  assign ERR_CNT          = err_cnt_q;
  assign FAIL_VALID       = fail_valid_q;
  assign FIRST_FAIL       = first_fail_q;

endmodule

// File: tb/tb_or4_vec_checker.sv
// -----------------------------------------------------------------------------
// tb_or4_vec_checker
//
// Self-checking bench for or4_vec_checker with SETTLE_CYC = 2. The gate under
// test is modelled as OR4 of the DUT's stimulus pins XOR a per-vector fault
// mask. Each sweep's expected results come from a reference model. That model
// walks the 16 vectors and applies the checking rules directly.
// -----------------------------------------------------------------------------
module tb_or4_vec_checker;

  localparam int S = 2;

  logic       CK;
  logic       RN;
  logic       START;
  logic       INV;
  logic       ZN;
  logic       A1, A2, A3, A4;
  logic       BUSY;
  logic       DONE;
  logic [4:0] ERR_CNT;
  logic       FAIL_VALID;
  logic [3:0] FIRST_FAIL;

  logic [15:0] zn_mask;
  logic [3:0]  a_vec;

  int tests;
  int fails;

  or4_vec_checker #(.SETTLE_CYC(S)) dut (
    .CK         (CK),
    .RN         (RN),
    .START      (START),
    .INV        (INV),
    .ZN         (ZN),
    .A1         (A1),
    .A2         (A2),
    .A3         (A3),
    .A4         (A4),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERR_CNT    (ERR_CNT),
    .FAIL_VALID (FAIL_VALID),
    .FIRST_FAIL (FIRST_FAIL)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  assign a_vec = {A1, A2, A3, A4};
  // Gate under test: OR4, with output inverted on vectors flagged in the mask.
  assign ZN    = (|a_vec) ^ zn_mask[a_vec];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the result for a whole sweep, derived from the gate
  // behaviour and the expected function.
  task automatic model(input logic [15:0] mask, input logic inv,
                       output int errs, output logic [3:0] first, output logic fv);
    errs  = 0;
    first = 4'd0;
    fv    = 1'b0;
    for (int v = 0; v < 16; v++) begin
      logic gate_out;
      logic want;
      gate_out = (v != 0) ^ mask[v];
      want     = (v != 0) ^ inv;
      if (gate_out != want) begin
        if (!fv) first = 4'(v);
        fv   = 1'b1;
        errs = errs + 1;
      end
    end
  endtask

  // One complete sweep. If pulse_at >= 1, a stray START is presented at that
  // cycle of the run.
  task automatic run_sweep(input logic [15:0] mask, input logic inv,
                           input int pulse_at, input string tag);
    int         m_errs;
    logic [3:0] m_first;
    logic       m_fv;
    model(mask, inv, m_errs, m_first, m_fv);
    zn_mask = mask;
    INV     = inv;
    @(negedge CK);
    START = 1'b1;
    @(posedge CK);
    #1;
    check({tag, ":start_busy"}, 32'(BUSY), 32'd1);
    check({tag, ":start_done"}, 32'(DONE), 32'd0);
    check({tag, ":start_clr"}, 32'({ERR_CNT, FAIL_VALID, FIRST_FAIL}), 32'd0);
    check({tag, ":vec0"}, 32'(a_vec), 32'd0);
    START = 1'b0;
    INV   = ~inv;  // the latched polarity must not follow the pin
    for (int k = 1; k < 16 * S; k++) begin
      START = (k == pulse_at);
      @(posedge CK);
      #1;
      check({tag, ":run_busy_vec"}, 32'({BUSY, DONE, a_vec}), 32'({1'b1, 1'b0, 4'(k / S)}));
    end
    START = 1'b0;
    @(posedge CK);
    #1;
    check({tag, ":end_state"}, 32'({BUSY, DONE, a_vec}), 32'({1'b0, 1'b1, 4'd0}));
    check({tag, ":err_cnt"}, 32'(ERR_CNT), 32'(m_errs));
    check({tag, ":fail_valid"}, 32'(FAIL_VALID), 32'(m_fv));
    check({tag, ":first_fail"}, 32'(FIRST_FAIL), 32'(m_first));
    repeat (3) @(posedge CK);
    #1;
    check({tag, ":hold"}, 32'({DONE, BUSY, ERR_CNT, FAIL_VALID, FIRST_FAIL}),
          32'({1'b1, 1'b0, 5'(m_errs), m_fv, m_first}));
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    RN      = 1'b0;
    START   = 1'b0;
    INV     = 1'b0;
    zn_mask = 16'h0000;

    // Reset state
    #12;
    check("reset_outputs",
          32'({a_vec, BUSY, DONE, ERR_CNT, FAIL_VALID, FIRST_FAIL}), 32'd0);
    @(negedge CK);
    RN = 1'b1;
    repeat (2) @(posedge CK);
    #1;
    check("idle_after_reset", 32'({a_vec, BUSY, DONE}), 32'd0);

    // Directed sweeps: OR4 good, stuck-0, stuck-1, wrong polarity, NOR4 good
    run_sweep(16'h0000, 1'b0, -1, "or4_good");
    run_sweep(16'hFFFE, 1'b0, -1, "stuck0");
    check("stuck0_count", 32'(ERR_CNT), 32'd15);
    check("stuck0_first", 32'(FIRST_FAIL), 32'd1);
    run_sweep(16'h0001, 1'b0, -1, "stuck1");
    check("stuck1_count", 32'(ERR_CNT), 32'd1);
    run_sweep(16'h0000, 1'b1, -1, "or4_vs_nor");
    check("or4_vs_nor_count", 32'(ERR_CNT), 32'd16);
    run_sweep(16'hFFFF, 1'b1, -1, "nor4_good");
    check("nor4_good_count", 32'(ERR_CNT), 32'd0);

    // Asynchronous reset mid-run, partway through a failing sweep
    zn_mask = 16'hFFFE;
    INV     = 1'b0;
    @(negedge CK);
    START = 1'b1;
    @(negedge CK);
    START = 1'b0;
    repeat (10) @(posedge CK);
    #3;
    check("pre_abort_busy", 32'({BUSY, FAIL_VALID}), 32'b11);
    RN = 1'b0;
    #1;
    check("abort_outputs",
          32'({a_vec, BUSY, DONE, ERR_CNT, FAIL_VALID, FIRST_FAIL}), 32'd0);
    @(posedge CK);
    #2;
    RN = 1'b1;
    run_sweep(16'hFFFE, 1'b0, -1, "after_abort");

    // A stray START during the run must be ignored
    run_sweep(16'hFFFE, 1'b0, 5, "start_in_run");

    // Randomized fault masks and polarities
    for (int r = 0; r < 6; r++) begin
      logic [15:0] m;
      logic        iv;
      m  = 16'($urandom);
      iv = 1'($urandom_range(0, 1));
      run_sweep(m, iv, (r == 2) ? int'($urandom_range(1, 30)) : -1, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Keeps the bench from hanging if something goes wrong.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
